// File: rtl/regbank_pkg.sv
// regbank_pkg: shared widths and clear-FSM state encoding for the register bank
package regbank_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;
endpackage

// File: rtl/regbank_if.sv
// regbank_if: write/read/clear bus between a register bank and its user
interface regbank_if #(
  parameter int DW = regbank_pkg::DATA_WIDTH,
  parameter int AW = regbank_pkg::ADDR_WIDTH
) ();
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] data_in;
  logic          read_enable_a;
  logic          read_enable_b;
  logic [AW-1:0] read_addr_a;
  logic [AW-1:0] read_addr_b;
  logic [DW-1:0] data_out_a;
  logic [DW-1:0] data_out_b;
  logic          clear_req;
  logic          busy;
  modport master (
    output write_enable, write_addr, data_in, read_enable_a, read_enable_b,
           read_addr_a, read_addr_b, clear_req,
    input  data_out_a, data_out_b, busy
  );
  modport slave (
    input  write_enable, write_addr, data_in, read_enable_a, read_enable_b,
           read_addr_a, read_addr_b, clear_req,
    output data_out_a, data_out_b, busy
  );
endinterface

// File: rtl/regbank_clear_ctrl.sv
// regbank_clear_ctrl: walks an index over every entry, one per cycle, after a clear request
module regbank_clear_ctrl #(
  parameter int AW = regbank_pkg::ADDR_WIDTH
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear_req_i,
  output logic          busy_o,
  output logic [AW-1:0] clr_idx_o,
  output logic          clr_en_o
);
  import regbank_pkg::*;
  localparam logic [AW-1:0] LAST = '1;
  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
  // clear_req is only looked at in IDLE, so a request mid-clear neither restarts nor extends it
  always_comb begin
    state_d   = state_q == IDLE ? (clear_req_i ? CLEAR : IDLE) : (idx_q == LAST ? IDLE : CLEAR);
    idx_d     = state_q == CLEAR ? idx_q + 1'b1 : '0;
    busy_o    = state_q == CLEAR;
    clr_en_o  = state_q == CLEAR;
    clr_idx_o = idx_q;
  end
endmodule

// File: rtl/regbank_file.sv
// regbank_file: two-read one-write register bank with write bypass, zero register and sequenced clear
module regbank_file #(
  parameter int DATA_WIDTH = regbank_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regbank_pkg::ADDR_WIDTH,
  parameter bit ZERO_REG   = 1'b1
) (
  input logic      clock,
  input logic      reset_n,
  regbank_if.slave bus
);
  import regbank_pkg::*;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  busy, clr_en, wr, zero_a, zero_b, byp_a, byp_b;
  regbank_clear_ctrl #(.AW(ADDR_WIDTH)) u_clear_ctrl (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_req_i(bus.clear_req),
    .busy_o     (busy),
    .clr_idx_o  (clr_idx),
    .clr_en_o   (clr_en)
  );
  // zero register wins over bypass; a busy bank returns 0 for every enabled read
  always_comb begin
    wr       = bus.write_enable && !busy;
    zero_a   = ZERO_REG && bus.read_addr_a == '0;
    zero_b   = ZERO_REG && bus.read_addr_b == '0;
    byp_a    = wr && bus.write_addr == bus.read_addr_a;
    byp_b    = wr && bus.write_addr == bus.read_addr_b;
    dout_a_d = !bus.read_enable_a ? dout_a_q : (busy || zero_a) ? '0 :
               byp_a ? bus.data_in : mem_q[bus.read_addr_a];
    dout_b_d = !bus.read_enable_b ? dout_b_q : (busy || zero_b) ? '0 :
               byp_b ? bus.data_in : mem_q[bus.read_addr_b];
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      if (wr && !(ZERO_REG && bus.write_addr == '0)) mem_q[bus.write_addr] <= bus.data_in;
      if (clr_en) mem_q[clr_idx] <= '0;
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end
  assign bus.data_out_a = dout_a_q;
  assign bus.data_out_b = dout_b_q;
  assign bus.busy       = busy;
endmodule

// File: tb/tb_regbank_file.sv
// tb_regbank_file: directed table, clear/reset sequences and random traffic against a reference model
module tb_regbank_file;
  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;
  regbank_if bus ();
  regbank_file dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_mem [32];
  logic [31:0] m_a, m_b;
  int          m_left;
  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] din;
    logic rea; logic [4:0] raa; logic reb; logic [4:0] rab;
    logic [31:0] ea; logic [31:0] eb;
  } vec_t;
  vec_t tbl [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_a = '0;
    m_b = '0;
    m_left = 0;
  endtask
  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return '0;
    if (bus.write_enable && bus.write_addr == a) return bus.data_in;
    return m_mem[a];
  endfunction
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] din,
                       input logic rea, input logic [4:0] raa, input logic reb,
                       input logic [4:0] rab, input logic clr);
    bus.write_enable = we; bus.write_addr = wa; bus.data_in = din;
    bus.read_enable_a = rea; bus.read_addr_a = raa;
    bus.read_enable_b = reb; bus.read_addr_b = rab;
    bus.clear_req = clr;
  endtask
  // advance the model by one clock from the current inputs, then take the edge and compare
  task automatic cycle();
    if (m_left > 0) begin
      if (bus.read_enable_a) m_a = '0;
      if (bus.read_enable_b) m_b = '0;
      m_mem[32 - m_left] = '0;
      m_left--;
    end else begin
      if (bus.read_enable_a) m_a = m_rd(bus.read_addr_a);
      if (bus.read_enable_b) m_b = m_rd(bus.read_addr_b);
      if (bus.write_enable && bus.write_addr != 0) m_mem[bus.write_addr] = bus.data_in;
      if (bus.clear_req) m_left = 32;
    end
    @(posedge clock);
    #1;
    chk("model_dout_a", bus.data_out_a, m_a);
    chk("model_dout_b", bus.data_out_b, m_b);
    chk("model_busy", 32'(bus.busy), 32'(m_left > 0));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int cnt;
    tbl[0] = '{1'b1, 5'd7, 32'hF305218F, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 32'hF305218F, 32'h0};
    tbl[2] = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd7, 1'b1, 5'd3, 32'hF305218F, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0};
    tbl[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0, 32'hF305218F, 32'h0};
    tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b0, 5'd0, 32'hF305218F, 32'h0};
    tbl[7] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF};
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    chk("rst_dout_a", bus.data_out_a, 32'h0);
    chk("rst_dout_b", bus.data_out_b, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].din, tbl[i].rea, tbl[i].raa, tbl[i].reb, tbl[i].rab, 1'b0);
      cycle();
      chk($sformatf("tbl%0d_a", i), bus.data_out_a, tbl[i].ea);
      chk($sformatf("tbl%0d_b", i), bus.data_out_b, tbl[i].eb);
    end
    // fill, clear, and confirm writes and a second request are ignored while busy
    for (int i = 1; i < 32; i++) begin
      drive(1, 5'(i), 32'h5A000000 | 32'(i), 0, 0, 0, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    cnt = bus.busy ? 1 : 0;
    drive(1, 9, 32'hFFFFFFFF, 1, 1, 0, 0, 0);
    while (bus.busy && cnt < 40) begin
      bus.clear_req = (cnt == 5);
      cycle();
      if (bus.busy) cnt++;
    end
    chk("busy_len", 32'(cnt), 32'd32);
    chk("busy_read_a", bus.data_out_a, 32'h0);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 1, 5'(i), 1, 5'(31 - i), 0);
      cycle();
      chk("clr_read_a", bus.data_out_a, 32'h0);
      chk("clr_read_b", bus.data_out_b, 32'h0);
    end
    // abort a clear with reset at its tenth cycle
    drive(1, 4, 32'h11112222, 0, 0, 0, 0, 0);
    cycle();
    drive(1, 30, 32'h33334444, 1, 4, 1, 4, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    bus.clear_req = 1'b0;
    repeat (9) cycle();
    chk("pre_abort_a", bus.data_out_a, 32'h11112222);
    reset_n = 1'b0;
    model_reset();
    #2;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_dout_a", bus.data_out_a, 32'h0);
    chk("abort_dout_b", bus.data_out_b, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(1, 5, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 1, 5, 1, 30, 0);
    cycle();
    chk("post_rst_a", bus.data_out_a, 32'hA5A5A5A5);
    chk("post_rst_b", bus.data_out_b, 32'h0);
    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom), 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)),
            $urandom, 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 31)), $urandom_range(0, 49) == 0);
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regbank_file.md
REGBANK_FILE -- requirements
Module: regbank_file

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, register index width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, when 1 entry 0 reads as zero and ignores writes.
REQ-004 The block SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-005 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port write_enable  input  1  write strobe for write port.
REQ-007 The block SHALL have port write_addr  input  ADDR_WIDTH  write index.
REQ-008 The block SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-009 The block SHALL have ports read_enable_a / read_enable_b  input  1  read strobes, ports A and B.
REQ-010 The block SHALL have ports read_addr_a / read_addr_b  input  ADDR_WIDTH  read indices.
REQ-011 The block SHALL have ports data_out_a / data_out_b  output  DATA_WIDTH  registered read data.
REQ-012 The block SHALL have port clear_req  input  1  request to zero all entries.
REQ-013 The block SHALL have port busy  output  1  high while clear sequence runs.

Function
REQ-014 The block SHALL, on write_enable=1 in IDLE, store data_in into entry write_addr at the rising edge.
REQ-015 The block SHALL, on read_enable_x=1, load data_out_x with entry read_addr_x at the rising edge (latency 1 cycle); with read_enable_x=0 data_out_x holds.
REQ-016 The block SHALL bypass write to read: same-cycle write_enable=1, read_enable_x=1, write_addr==read_addr_x, IDLE -> data_out_x = data_in.
REQ-017 The block SHALL, when ZERO_REG=1, ignore writes to entry 0 and return 0 for reads of entry 0, including the bypass case.
REQ-018 The block SHALL implement FSM states IDLE and CLEAR; IDLE -> CLEAR on clear_req=1; CLEAR -> IDLE after zeroing entry DEPTH-1.
REQ-019 The block SHALL, in CLEAR, zero one entry per cycle using an index counter starting at 0, incrementing by 1, busy=1 for exactly DEPTH cycles.
REQ-020 The block SHALL ignore write_enable while busy=1; a write and clear_req in the same IDLE cycle both apply (write lands, then is cleared).
REQ-021 The block SHALL load data_out_x with 0 for any enabled read while busy=1.
REQ-022 The block SHALL ignore clear_req while in CLEAR (no restart, no extension).
REQ-023 The block SHALL permit reads on both ports at the same address in the same cycle, returning identical data.
REQ-024 The block SHALL wrap the clear counter to 0 on return to IDLE; no out-of-range entry access.

Reset
REQ-025 The block SHALL, on reset_n=0, immediately zero all entries, data_out_a, data_out_b, the clear counter, set busy=0 and state IDLE.
REQ-026 The block SHALL abort an in-progress clear on reset_n=0 mid-sequence; operation resumes in IDLE after release.
REQ-027 The block SHALL accept first write on the first rising edge with reset_n=1.

Structure
REQ-028 The block SHALL take DATA_WIDTH/ADDR_WIDTH defaults and the IDLE/CLEAR state encoding from shared package regbank_pkg.
REQ-029 The block SHALL place the clear FSM and index counter in sub-module regbank_clear_ctrl (outputs busy, clear index, clear strobe).
REQ-030 The block SHALL keep storage, bypass and read registers in regbank_file itself.

Verification
REQ-031 The bench SHALL write 32'hF305218F to entry 7, then read port A at 7 -> data_out_a=32'hF305218F one cycle after read_enable_a.
REQ-032 The bench SHALL write 32'hDEADBEEF to entry 3 while reading port B at 3 in the same cycle -> data_out_b=32'hDEADBEEF next edge.
REQ-033 The bench SHALL write 32'h12345678 to entry 0 (ZERO_REG=1), read both ports at 0 -> both outputs 0.
REQ-034 The bench SHALL fill entries 1..31 with nonzero data, pulse clear_req -> busy=1 for 32 cycles, write during busy ignored, all entries read 0 afterwards.
REQ-035 The bench SHALL assert reset_n=0 at clear cycle 10 -> busy=0 and outputs 0 immediately; after release write/read entry 5 with 32'hA5A5A5A5 succeeds.
REQ-036 The bench SHALL, with read_enable_a=0 after reading 32'hF305218F, change read_addr_a -> data_out_a holds 32'hF305218F.
